// File: rtl/lycan_globals.sv
// System-wide widths shared by the USB bridge and every peripheral.
package lycan_globals;
    localparam int usb_packet_width     = 32;
    localparam int periph_address_width = 3;
endpackage

// File: rtl/periph_rx_mux_pkg.sv
// Types and sizing helpers for the peripheral RX -> USB TX multiplexer.
package periph_rx_mux_pkg;
    localparam int ADDR_W = lycan_globals::periph_address_width;
    localparam int DATA_W = lycan_globals::usb_packet_width - ADDR_W;

    typedef enum logic {
        ARB,
        XFER
    } rx_mux_state_t;

    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

    localparam int DEF_MAX_BURST = 4;
    localparam int BURST_CNT_W   = burst_cnt_w(DEF_MAX_BURST);
endpackage

// File: rtl/periph_rx_mux_rr_arbiter.sv
// Rotate-priority pick: the requester just after `last` wins, `last` itself
// has the lowest priority.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] gnt,
    output logic          valid
);
    always_comb begin
        int idx;
        logic [AW-1:0] sel;
        idx   = 0;
        sel   = '0;
        gnt   = last;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            sel = AW'(idx);
            if (!valid && req[sel]) begin
                valid = 1'b1;
                gnt   = sel;
            end
        end
    end
endmodule

// File: rtl/periph_rx_mux.sv
// Round-robin drain of the peripheral RX FIFOs into the USB TX FIFO,
// tagging each packet with the source peripheral address.
module periph_rx_mux
    import lycan_globals::*;
    import periph_rx_mux_pkg::*;
#(
    parameter int NUM_PERIPHS = 8,
    parameter int MAX_BURST   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PERIPHS-1:0][DATA_W-1:0]  periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]              periph_rx_empty,
    output logic [NUM_PERIPHS-1:0]              periph_rx_rden,
    input  logic [NUM_PERIPHS-1:0]              periph_enable,
    output logic [usb_packet_width-1:0]         usb_tx_data,
    output logic                                usb_tx_wren,
    input  logic                                usb_tx_full,
    output logic [periph_address_width-1:0]     grant_id,
    output logic                                busy
);
    localparam int AW = periph_address_width;
    localparam int BW = burst_cnt_w(MAX_BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [AW-1:0] RST_GRANT = AW'(NUM_PERIPHS - 1);

    if (NUM_PERIPHS > (1 << AW)) begin : g_bad_periphs
        $error("NUM_PERIPHS exceeds the peripheral address space");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    rx_mux_state_t   state_q, state_d;
    logic [AW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;

    logic [NUM_PERIPHS-1:0] elig;
    logic                   cur_elig;
    logic                   pop;
    logic [AW-1:0]          arb_gnt;
    logic                   arb_valid;

    assign elig     = ~periph_rx_empty & periph_enable;
    assign cur_elig = elig[grant_q];
    assign busy     = (state_q == XFER);
    assign pop      = busy & cur_elig & ~usb_tx_full;

    rr_arbiter #(
        .N  (NUM_PERIPHS),
        .AW (AW)
    ) u_arb (
        .req   (elig),
        .last  (grant_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        unique case (state_q)
            ARB: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    burst_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                // An empty or disabled source ends the burst even if full.
                if (!cur_elig) begin
                    state_d = ARB;
                end else if (pop) begin
                    if (burst_q == LAST_BEAT) begin
                        state_d = ARB;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            grant_q <= RST_GRANT;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        periph_rx_rden = '0;
        if (pop) begin
            periph_rx_rden[grant_q] = 1'b1;
        end
    end

    assign usb_tx_wren = pop;
    assign usb_tx_data = busy ? {grant_q, periph_rx_data[grant_q]} : '0;
    assign grant_id    = grant_q;
endmodule

// File: tb/tb_periph_rx_mux.sv
// Self-checking bench for periph_rx_mux: FWFT FIFO models per peripheral
// plus an ordered scoreboard of expected USB packets.
module tb_periph_rx_mux;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 29;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0][DW-1:0] rx_data;
    logic [N-1:0]         rx_empty;
    logic [N-1:0]         rx_rden;
    logic [N-1:0]         enable;
    logic [31:0]          tx_data;
    logic                 tx_wren;
    logic                 tx_full;
    logic [AW-1:0]        grant;
    logic                 busy;

    periph_rx_mux #(
        .NUM_PERIPHS (N),
        .MAX_BURST   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .periph_rx_data  (rx_data),
        .periph_rx_empty (rx_empty),
        .periph_rx_rden  (rx_rden),
        .periph_enable   (enable),
        .usb_tx_data     (tx_data),
        .usb_tx_wren     (tx_wren),
        .usb_tx_full     (tx_full),
        .grant_id        (grant),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo [N][$];
    logic [31:0]   sb [$];
    int            wr_cyc [$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    logic          s_wren, s_busy;
    logic [N-1:0]  s_rden;
    logic [AW-1:0] s_grant;
    logic [31:0]   s_data;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            rx_empty[i] = (fifo[i].size() == 0);
            rx_data[i]  = rx_empty[i] ? '0 : fifo[i][0];
        end
    endtask

    task automatic push_fifo(input int p, input logic [DW-1:0] d);
        fifo[p].push_back(d);
        refresh();
    endtask

    task automatic expect_pkt(input int p, input logic [DW-1:0] d);
        sb.push_back({AW'(p), d});
    endtask

    // One clock: sample/score at negedge, then apply FIFO pops after posedge.
    task automatic tick();
        logic [N-1:0] pend;
        logic [N-1:0] exp_rden;
        logic [31:0]  exp;
        @(negedge clk);
        cyc++;
        s_wren  = tx_wren;
        s_busy  = busy;
        s_rden  = rx_rden;
        s_grant = grant;
        s_data  = tx_data;
        if (tx_wren) begin
            checks++;
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data=%h, none expected", tx_data);
            end else begin
                exp = sb.pop_front();
                exp_rden = '0;
                exp_rden[exp[31:29]] = 1'b1;
                if (tx_data !== exp || rx_rden !== exp_rden) begin
                    errors++;
                    $display("FAIL write_data: got data=%h rden=%b, want data=%h rden=%b",
                             tx_data, rx_rden, exp, exp_rden);
                end
            end
            checks++;
            if (tx_full !== 1'b0) begin
                errors++;
                $display("FAIL write_while_full: wren=1 full=%b, want full=0", tx_full);
            end
        end
        if (rx_rden !== '0 && tx_wren !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pop_without_write: rden=%b wren=%b, want wren=1", rx_rden, tx_wren);
        end
        for (int i = 0; i < N; i++) begin
            if (rx_rden[i] === 1'b1 && fifo[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_empty: rden[%0d]=1 on empty FIFO, want 0", i);
            end
        end
        pend = rst ? '0 : rx_rden;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && sb.size() > 0; c++) tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) push_fifo(i, DW'(29'h100 + i));
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (s_rden !== '0 || s_wren !== 1'b0 || s_busy !== 1'b0 ||
                s_grant !== 3'd7 || s_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: rden=%b wren=%b busy=%b grant=%0d data=%h, want 0/0/0/7/0",
                         s_rden, s_wren, s_busy, s_grant, s_data);
            end
        end
        for (int i = 0; i < N; i++) fifo[i].delete();
        refresh();
        rst = 1'b0;
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_grant !== 3'd7) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b grant=%0d, want 0/7", s_busy, s_grant);
        end
    endtask

    task automatic test_single();
        bit exp_wren [6] = '{0, 1, 1, 1, 0, 0};
        bit exp_busy [6] = '{0, 1, 1, 1, 1, 0};
        for (int k = 1; k <= 3; k++) begin
            push_fifo(2, 29'h0A000000 + DW'(k));
            expect_pkt(2, 29'h0A000000 + DW'(k));
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (s_wren !== exp_wren[c] || s_busy !== exp_busy[c]) begin
                errors++;
                $display("FAIL single_seq[%0d]: wren=%b busy=%b, want %b/%b",
                         c, s_wren, s_busy, exp_wren[c], exp_busy[c]);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_drain: %0d packets left, want 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            push_fifo(1, 29'h01000000 + DW'(k));
            push_fifo(5, 29'h05000000 + DW'(k));
        end
        for (int k = 0; k < 4; k++) expect_pkt(1, 29'h01000000 + DW'(k));
        for (int k = 0; k < 4; k++) expect_pkt(5, 29'h05000000 + DW'(k));
        for (int k = 4; k < 6; k++) expect_pkt(1, 29'h01000000 + DW'(k));
        for (int k = 4; k < 6; k++) expect_pkt(5, 29'h05000000 + DW'(k));
        drain(60);
        checks++;
        if (sb.size() != 0 || wr_cyc.size() != 12) begin
            errors++;
            $display("FAIL rr_drain: left=%0d writes=%0d, want 0/12", sb.size(), wr_cyc.size());
        end else begin
            checks++;
            if (wr_cyc[1] - wr_cyc[0] != 1) begin
                errors++;
                $display("FAIL rr_full_rate: gap=%0d, want 1", wr_cyc[1] - wr_cyc[0]);
            end
            checks++;
            if (wr_cyc[4] - wr_cyc[3] != 2 || wr_cyc[8] - wr_cyc[7] != 2) begin
                errors++;
                $display("FAIL rr_bubble: gaps=%0d,%0d, want 2,2",
                         wr_cyc[4] - wr_cyc[3], wr_cyc[8] - wr_cyc[7]);
            end
        end
    endtask

    task automatic test_full_stall();
        int n;
        wr_cyc.delete();
        for (int k = 0; k < 6; k++) begin
            push_fifo(6, 29'h06000000 + DW'(k));
            expect_pkt(6, 29'h06000000 + DW'(k));
        end
        for (int c = 0; c < 20 && wr_cyc.size() < 2; c++) tick();
        checks++;
        if (wr_cyc.size() < 2) begin
            errors++;
            $display("FAIL stall_start_timeout: writes=%0d, want 2", wr_cyc.size());
        end
        tx_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (s_wren !== 1'b0 || s_rden !== '0 || s_grant !== 3'd6 || s_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: wren=%b rden=%b grant=%0d busy=%b, want 0/0/6/1",
                         c, s_wren, s_rden, s_grant, s_busy);
            end
        end
        tx_full = 1'b0;
        n = 0;
        tick();
        for (int c = 0; c < 10 && s_wren === 1'b1; c++) begin
            n++;
            tick();
        end
        checks++;
        if (n != 2 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume: pops=%0d busy_after=%b, want 2/0", n, s_busy);
        end
        drain(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d packets left, want 0", sb.size());
        end
    endtask

    task automatic test_enable();
        wr_cyc.delete();
        enable[3] = 1'b0;
        push_fifo(3, 29'h03000000);
        push_fifo(3, 29'h03000001);
        for (int k = 0; k < 6; k++) begin
            push_fifo(6, 29'h06100000 + DW'(k));
            expect_pkt(6, 29'h06100000 + DW'(k));
        end
        for (int c = 0; c < 20 && wr_cyc.size() < 2; c++) tick();
        enable[6] = 1'b0;
        tick();
        checks++;
        if (s_wren !== 1'b0 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_drop: wren=%b busy=%b, want 0/1", s_wren, s_busy);
        end
        tick();
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_exit: busy=%b, want 0", s_busy);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (s_busy !== 1'b0 || s_wren !== 1'b0) begin
                errors++;
                $display("FAIL disabled_granted: busy=%b wren=%b grant=%0d, want 0/0",
                         s_busy, s_wren, s_grant);
            end
        end
        enable[6] = 1'b1;
        drain(30);
        checks++;
        if (sb.size() != 0 || wr_cyc.size() != 6) begin
            errors++;
            $display("FAIL enable_drain: left=%0d writes=%0d, want 0/6", sb.size(), wr_cyc.size());
        end
        fifo[3].delete();
        refresh();
        enable[3] = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [AW-1:0] first;
        wr_cyc.delete();
        for (int k = 0; k < 4; k++) push_fifo(4, 29'h04000000 + DW'(k));
        expect_pkt(4, 29'h04000000);
        expect_pkt(0, 29'h00000010);
        expect_pkt(0, 29'h00000011);
        for (int k = 1; k < 4; k++) expect_pkt(4, 29'h04000000 + DW'(k));
        for (int c = 0; c < 20 && wr_cyc.size() < 1; c++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (rx_rden !== '0 || tx_wren !== 1'b0 || busy !== 1'b0 || tx_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: rden=%b wren=%b busy=%b data=%h, want all 0",
                     rx_rden, tx_wren, busy, tx_data);
        end
        push_fifo(0, 29'h00000010);
        push_fifo(0, 29'h00000011);
        tick();
        tick();
        rst = 1'b0;
        seen = 1'b0;
        first = '0;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            tick();
            if (s_busy === 1'b1 && !seen) begin
                seen = 1'b1;
                first = s_grant;
            end
        end
        checks++;
        if (!seen || first !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_regrant: seen=%b first=%0d left=%0d, want 1/0/0",
                     seen, first, sb.size());
        end
    endtask

    initial begin
        rst     = 1'b1;
        tx_full = 1'b0;
        enable  = '1;
        refresh();
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_enable();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
